// File: rtl/riscv_types_pkg.sv
// Shared types for the RV32IM pipeline front end: IF/ID entry, fetch FSM states,
// instruction size.
package riscv_types_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } if_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of IF/ID entries; head is read combinationally from storage.
// Clear empties it; push and pop in the same cycle keep the count, even when full.
import riscv_types_pkg::*;

module fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  if_entry_t                wdata_i,
  input  logic                     pop_i,
  output if_entry_t                rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// RV32IM instruction fetch: owns the PC, issues word reads, buffers responses for IF/ID.
// Optional FETCH_PERF_CNT_EN adds handshake and discarded-response counters.
import riscv_types_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         stall_f_i,
  input  logic         flush_f_i,
  input  logic         pc_redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic [31:0]  i_araddr_o,
  output logic         i_arvalid_o,
  input  logic         i_arready_i,
  input  logic         i_rvalid_i,
  input  logic [31:0]  i_rdata_i,
  input  logic         i_rerr_i,
  output logic         valid_f_o,
  output logic [31:0]  pc_f_o,
  output logic [31:0]  instr_f_o,
  output logic         fault_f_o,
  output fetch_state_e dbg_state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetch_cnt_o,
  output logic [31:0]  perf_discard_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   deliver_pc_q, deliver_pc_d;
  logic [31:0]   tail_pc_q, tail_pc_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic          pend_q, pend_d;
  logic          pend_stale_q, pend_stale_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          kill, credit_ok, req_valid, hs, stale_hs;
  logic          drop, push, pop;
  logic [31:0]   req_addr, new_pc;
  if_entry_t     head, push_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  assign kill       = pc_redirect_i | flush_f_i;
  assign new_pc     = pc_redirect_i ? redirect_pc_i : deliver_pc_q;
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  // A request that was presented but not yet accepted stays on the bus unchanged.
  assign req_valid  = pend_q | ((state_q == RUN) & credit_ok);
  assign req_addr   = pend_q ? pend_addr_q : {fetch_pc_q[31:2], 2'b00};
  assign hs         = req_valid & i_arready_i;
  assign stale_hs   = hs & pend_q & pend_stale_q;
  assign drop       = i_rvalid_i & (discard_q != '0);
  assign push       = i_rvalid_i & ~drop & ~kill;
  assign pop        = ~fifo_empty & ~stall_f_i & ~kill;
  assign push_entry = '{pc: tail_pc_q, instr: i_rdata_i, fault: i_rerr_i};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    tail_pc_d    = tail_pc_q;
    pend_d       = req_valid & ~i_arready_i;
    pend_addr_d  = req_addr;
    pend_stale_d = pend_d & (kill | (pend_q & pend_stale_q));
    outst_d      = outst_q + CW'(hs) - CW'(i_rvalid_i);
    discard_d    = discard_q + CW'(stale_hs) - CW'(drop);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (push && i_rerr_i) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase

    if (kill) begin
      state_d      = RUN;
      fetch_pc_d   = new_pc;
      deliver_pc_d = new_pc;
      tail_pc_d    = new_pc;
      // Everything still owed by memory, including a same-cycle handshake, is dropped.
      discard_d    = outst_q - CW'(i_rvalid_i) + CW'(hs);
    end else begin
      if (hs && !stale_hs) fetch_pc_d = fetch_pc_q + INSTR_BYTES;
      if (pop)  deliver_pc_d = deliver_pc_q + INSTR_BYTES;
      if (push) tail_pc_d    = tail_pc_q + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_VECTOR;
      deliver_pc_q <= RESET_VECTOR;
      tail_pc_q    <= RESET_VECTOR;
      pend_q       <= 1'b0;
      pend_addr_q  <= RESET_VECTOR;
      pend_stale_q <= 1'b0;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      tail_pc_q    <= tail_pc_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_stale_q <= pend_stale_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (kill),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Credits bound in-flight plus buffered words, so a response never meets a full buffer.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));

  assign i_arvalid_o = req_valid;
  assign i_araddr_o  = req_addr;
  assign valid_f_o   = ~fifo_empty;
  assign pc_f_o      = head.pc;
  assign instr_f_o   = head.instr;
  assign fault_f_o   = head.fault;
  assign dbg_state_o = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_discard_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_q   <= '0;
      perf_discard_q <= '0;
    end else begin
      perf_fetch_q   <= perf_fetch_q + 32'(hs);
      perf_discard_q <= perf_discard_q + 32'(i_rvalid_i & (drop | kill));
    end
  end

  assign perf_fetch_cnt_o   = perf_fetch_q;
  assign perf_discard_cnt_o = perf_discard_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a zero-wait, in-order instruction memory model.
module tb_fetch_stage;
  import riscv_types_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall_f, flush_f, pc_redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  i_araddr;
  logic         i_arvalid, i_arready;
  logic         i_rvalid = 1'b0;
  logic [31:0]  i_rdata = '0;
  logic         i_rerr = 1'b0;
  logic         valid_f, fault_f;
  logic [31:0]  pc_f, instr_f;
  fetch_state_e dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  perf_fetch_cnt, perf_discard_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] req_q[$];
  logic [31:0] hs_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  logic        got_fault[$];
  logic        mem_hold = 1'b0;
  logic [31:0] err_addr = 32'h0000_0040;

  logic [31:0] exp_hs_q[$] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014,
                               32'h018, 32'h01C, 32'h020, 32'h020, 32'h024, 32'h028,
                               32'h02C, 32'h100, 32'h104, 32'h108, 32'h040, 32'h044,
                               32'h200, 32'h204};
  logic [31:0] exp_q[$] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014,
                            32'h018, 32'h01C, 32'h020, 32'h024, 32'h100, 32'h104,
                            32'h200, 32'h204};

  fetch_stage #(.RESET_VECTOR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_f_i     (stall_f),
    .flush_f_i     (flush_f),
    .pc_redirect_i (pc_redirect),
    .redirect_pc_i (redirect_pc),
    .i_araddr_o    (i_araddr),
    .i_arvalid_o   (i_arvalid),
    .i_arready_i   (i_arready),
    .i_rvalid_i    (i_rvalid),
    .i_rdata_i     (i_rdata),
    .i_rerr_i      (i_rerr),
    .valid_f_o     (valid_f),
    .pc_f_o        (pc_f),
    .instr_f_o     (instr_f),
    .fault_f_o     (fault_f),
    .dbg_state_o   (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o   (perf_fetch_cnt),
    .perf_discard_cnt_o (perf_discard_cnt)
`endif
  );

  // Clock and reset-independent helpers.
  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: accepts on handshake, answers in order one cycle later unless held.
  initial begin : mem_model
    logic        go;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!rst && i_arvalid && i_arready) begin
        req_q.push_back(i_araddr);
        hs_log.push_back(i_araddr);
      end
      go = !mem_hold && (req_q.size() > 0);
      @(posedge clk);
      #1;
      if (go) begin
        a = req_q.pop_front();
        i_rvalid = 1'b1;
        i_rdata  = mem_word(a);
        i_rerr   = (a == err_addr);
      end else begin
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_rerr   = 1'b0;
      end
    end
  end

  // Records every entry IF/ID actually takes.
  initial begin : deliver_mon
    forever begin
      @(negedge clk);
      if (!rst && valid_f && !stall_f && !pc_redirect && !flush_f) begin
        got_pc.push_back(pc_f);
        got_instr.push_back(instr_f);
        got_fault.push_back(fault_f);
      end
    end
  end

  initial begin : stimulus
    i_arready = 1'b1; stall_f = 1'b0; flush_f = 1'b0;
    pc_redirect = 1'b0; redirect_pc = '0;

    #3;
    chk("rst_arvalid", 32'(i_arvalid), 32'd0);
    chk("rst_araddr", i_araddr, 32'h0);
    chk("rst_valid", 32'(valid_f), 32'd0);
    chk("rst_pc", pc_f, 32'h0);
    chk("rst_instr", instr_f, 32'h0);
    chk("rst_fault", 32'(fault_f), 32'd0);

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;                                   // cycle 0: BOOT
    #3; chk("boot_arvalid", 32'(i_arvalid), 32'd0);
    tick();                                       // cycle 1
    chk("c1_arvalid", 32'(i_arvalid), 32'd1);
    chk("c1_araddr", i_araddr, 32'h0);
    tick();                                       // cycle 2
    chk("c2_valid", 32'(valid_f), 32'd0);
    tick();                                       // cycle 3: first entry
    chk("c3_valid", 32'(valid_f), 32'd1);
    chk("c3_pc", pc_f, 32'h0);
    chk("c3_instr", instr_f, mem_word(32'h0));
    chk("c3_fault", 32'(fault_f), 32'd0);
    tick(); tick();
    tick(); i_arready = 1'b0;                     // cycle 6

    for (int i = 0; i < 4; i++) begin             // cycles 7..10: request held
      tick();
      chk("wait_arvalid", 32'(i_arvalid), 32'd1);
      chk("wait_araddr", i_araddr, 32'h10);
    end

    tick(); i_arready = 1'b1; stall_f = 1'b1;     // cycle 11
    tick();
    for (int i = 0; i < 3; i++) begin             // cycles 13..15: head held
      tick();
      chk("stall_valid", 32'(valid_f), 32'd1);
      chk("stall_pc", pc_f, 32'h10);
      chk("stall_instr", instr_f, mem_word(32'h10));
      chk("stall_credit", 32'(i_arvalid), 32'd0);
    end
    tick(); stall_f = 1'b0;                       // cycle 16
    tick(); tick();
    tick(); i_arready = 1'b0;                     // cycle 19
    tick(); tick();
    tick(); flush_f = 1'b1;                       // cycle 22: replay from 0x20
    chk("flush_held_arvalid", 32'(i_arvalid), 32'd1);
    chk("flush_held_araddr", i_araddr, 32'h20);
    tick(); flush_f = 1'b0; i_arready = 1'b1;     // cycle 23
    chk("flush_valid_off", 32'(valid_f), 32'd0);
    chk("flush_old_addr", i_araddr, 32'h20);
    tick(); tick();
    tick();                                       // cycle 26
    chk("flush_first_valid", 32'(valid_f), 32'd1);
    chk("flush_first_pc", pc_f, 32'h20);
    chk("flush_first_instr", instr_f, mem_word(32'h20));
    i_arready = 1'b0;
    tick(); tick();
    tick(); mem_hold = 1'b1; i_arready = 1'b1;    // cycle 29
    tick();
    tick();                                       // cycle 31: two in flight
    chk("redir_no_credit", 32'(i_arvalid), 32'd0);
    pc_redirect = 1'b1; redirect_pc = 32'h100; mem_hold = 1'b0;
    tick(); pc_redirect = 1'b0;                   // cycle 32
    chk("redir_valid_off", 32'(valid_f), 32'd0);
    chk("redir_still_owed", 32'(i_arvalid), 32'd0);
    tick();                                       // cycle 33
    chk("redir_arvalid", 32'(i_arvalid), 32'd1);
    chk("redir_araddr", i_araddr, 32'h100);
    tick();
    tick();                                       // cycle 35
    chk("redir_valid", 32'(valid_f), 32'd1);
    chk("redir_pc", pc_f, 32'h100);
    chk("redir_instr", instr_f, mem_word(32'h100));
    i_arready = 1'b0;
    tick();
    tick(); pc_redirect = 1'b1; redirect_pc = 32'h40;  // cycle 37
    tick(); pc_redirect = 1'b0; i_arready = 1'b1;      // cycle 38
    tick();
    tick(); stall_f = 1'b1;                            // cycle 40
    tick();                                            // cycle 41: faulting entry
    chk("fault_valid", 32'(valid_f), 32'd1);
    chk("fault_pc", pc_f, 32'h40);
    chk("fault_flag", 32'(fault_f), 32'd1);
    chk("fault_instr", instr_f, mem_word(32'h40));
    chk("fault_no_req", 32'(i_arvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin                  // cycles 42..44
      tick();
      chk("fault_quiet", 32'(i_arvalid), 32'd0);
      chk("fault_hold_pc", pc_f, 32'h40);
    end
    tick(); pc_redirect = 1'b1; redirect_pc = 32'h200; // cycle 45, kill beats stall
    tick(); pc_redirect = 1'b0; stall_f = 1'b0;        // cycle 46
    chk("recover_valid_off", 32'(valid_f), 32'd0);
    chk("recover_arvalid", 32'(i_arvalid), 32'd1);
    chk("recover_araddr", i_araddr, 32'h200);
    tick(); tick();                                    // cycle 48
    chk("recover_pc", pc_f, 32'h200);
    chk("recover_fault", 32'(fault_f), 32'd0);
    i_arready = 1'b0;
    repeat (6) tick();

    chk("hs_count", 32'(hs_log.size()), 32'(exp_hs_q.size()));
    for (int i = 0; i < exp_hs_q.size(); i++)
      if (i < hs_log.size()) chk($sformatf("hs_addr[%0d]", i), hs_log[i], exp_hs_q[i]);
    chk("deliver_count", 32'(got_pc.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_pc.size()) begin
        chk($sformatf("deliver_pc[%0d]", i), got_pc[i], exp_q[i]);
        chk($sformatf("deliver_instr[%0d]", i), got_instr[i], mem_word(exp_q[i]));
        chk($sformatf("deliver_fault[%0d]", i), 32'(got_fault[i]), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
